inst_fetch_queue: RTL and testbench
===================================

Name: inst_fetch_queue

Overview:
- Decoupling FIFO between the fetch stage (pif) and the IF/ID pipeline register (ifid).
- Buffers {pc, instruction} pairs so fetch keeps running while decode back-pressures.
- Discards all buffered entries on a control-flow redirect from the jump/stall path.
- Presents the oldest entry to ifid with a valid/ready handshake.

Parameters:
- DEPTH, 4: number of entries; power of two, at least 2.
- ADDR_WIDTH, 32: PC width.
- INST_WIDTH, 32: instruction word width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- flush  in  1  redirect from jump resolution; empties the queue.
- push_valid  in  1  fetch offers an entry.
- push_ready  out  1  queue accepts an entry (not full).
- push_pc  in  ADDR_WIDTH  PC of offered instruction.
- push_inst  in  INST_WIDTH  offered instruction word.
- pop_valid  out  1  head entry is available.
- pop_ready  in  1  ifid consumes the head entry.
- pop_pc  out  ADDR_WIDTH  head PC; 0 when pop_valid=0.
- pop_inst  out  INST_WIDTH  head instruction; 0 when pop_valid=0.
- count  out  $clog2(DEPTH+1)  number of occupied entries.

Behaviour:
- Reset: while rst=0 at a clock edge, head=0, tail=0, count=0. As a result pop_valid=0, pop_pc=0, pop_inst=0 and push_ready=1 from the following cycle. Reset wins over flush, push and pop.
- Push fires when push_valid & push_ready. The entry is written at tail and tail advances modulo DEPTH.
- Pop fires when pop_valid & pop_ready. head advances modulo DEPTH. The entry's storage is not cleared.
- push_ready = (count != DEPTH). This is combinational from count only. A pop in the same cycle does not open a full queue; there is no full pass-through.
- pop_valid = (count != 0). Data is taken combinationally from entry[head] and gated to 0 when the queue is empty.
- Latency: a pushed entry is visible at the pop side the cycle after the push edge (1 cycle).
- Simultaneous push and pop with 0 < count < DEPTH: both fire and count is unchanged.
- Push into an empty queue with pop_ready=1: only the push fires, because pop_valid=0 that cycle.
- flush=1 at an edge (rst=1): head=tail=count=0, and any push or pop that cycle is discarded. push_ready stays driven as normal during the flush cycle, but the accepted entry is dropped.
- Pointers are $clog2(DEPTH) bits and wrap naturally. count is maintained separately, which avoids full/empty ambiguity.
- pop_ready is ignored when pop_valid=0. push_pc and push_inst are ignored when push_valid=0.
- No X propagation: entry storage is not reset, but the output gating guarantees defined outputs.

Optional Feature:
- Macro IFQ_BYPASS_EN.
- Defined: when count==0, push_valid=1 and flush=0, pop_valid=1 and pop_pc/pop_inst equal push_pc/push_inst combinationally (0-cycle latency).
  - If pop_ready=1 in that cycle, the entry is consumed and not written; count stays 0.
  - If pop_ready=0, the entry is written as in normal operation.
- Not defined: no bypass path; minimum latency is 1 cycle as above.

Decomposition:
- common_def package holds:
  - typedef ifq_entry_t {logic [ADDR_WIDTH-1:0] pc; logic [INST_WIDTH-1:0] inst;}
  - constants IFQ_DEPTH_DEFAULT=4, ADDR_WIDTH=32, INST_WIDTH=32.
- One sub-module, ifq_ptr: a wrapping pointer register with inputs clk, rst, clr and inc. It is instantiated twice, for head and tail.

Test Plan:
- Reset/idle: hold rst=0 for 2 cycles, then release -> pop_valid=0, pop_pc=0, push_ready=1, count=0.
- Fill and drain: push pc 0x100/0x104/0x108/0x10C with pop_ready=0 -> count=4 and push_ready=0. Then pop_ready=1 -> pops in order 0x100..0x10C, count 3,2,1,0.
- Full with concurrent pop: at count=4 drive push_valid=1 and pop_ready=1 -> only the pop fires, count=3, and the pushed entry is not taken that cycle.
- Wrap-around: 10 cycles of push+pop at count=2 -> count stays 2, PCs exit in push order across the pointer wrap, no loss or duplication.
- Flush: at count=3 assert flush together with push_valid=1 -> next cycle count=0, pop_valid=0. A push of 0x200 in the following cycle exits first.
- Bypass: with IFQ_BYPASS_EN, empty queue, push 0x300 with pop_ready=1 -> pop_pc=0x300 in the same cycle and count remains 0. Without the macro -> pop_valid=1 with 0x300 one cycle later.

Source files
------------

// File: rtl/common_def.sv
// ============================================================================
// Package     : common_def
// Description : Shared types and default constants for the instruction fetch
//               queue that sits between the fetch stage and the IF/ID register.
//               - ifq_entry_t       : one buffered {pc, instruction} pair
//               - IFQ_DEPTH_DEFAULT : default number of queue entries
//               - ADDR_WIDTH        : default PC width
//               - INST_WIDTH        : default instruction word width
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package common_def;

  localparam int IFQ_DEPTH_DEFAULT = 4;
  localparam int ADDR_WIDTH        = 32;
  localparam int INST_WIDTH        = 32;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [INST_WIDTH-1:0] inst;
  } ifq_entry_t;

endpackage : common_def

`default_nettype wire

// File: rtl/ifq_ptr.sv
// ============================================================================
// Module      : ifq_ptr
// Description : Wrapping pointer register used for the queue head and tail.
//               The pointer is W bits wide and wraps naturally at 2**W.
// Ports       : clk   - clock, rising edge
//               rst   - synchronous active-low reset (pointer -> 0)
//               clr_i - synchronous clear (pointer -> 0), e.g. on redirect
//               inc_i - advance the pointer by one
//               ptr_o - current pointer value
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifq_ptr #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule : ifq_ptr

`default_nettype wire

// File: rtl/inst_fetch_queue.sv
// ============================================================================
// Module      : inst_fetch_queue
// Description : Decoupling FIFO between the fetch stage and the IF/ID register.
//               Buffers {pc, instruction} pairs, drops everything on a flush
//               (control-flow redirect) and presents the oldest entry with a
//               valid/ready handshake. Occupancy is kept in a separate counter
//               so full and empty are never ambiguous.
// Macro       : IFQ_BYPASS_EN - when defined, an empty queue forwards the
//               offered entry straight to the pop side in the same cycle.
// Ports       : clk          - clock, rising edge
//               rst          - synchronous active-low reset
//               flush_i      - redirect; empties the queue
//               push_valid_i - fetch offers an entry
//               push_ready_o - queue can accept an entry (not full)
//               push_pc_i    - PC of the offered instruction
//               push_inst_i  - offered instruction word
//               pop_valid_o  - head entry available
//               pop_ready_i  - consumer takes the head entry
//               pop_pc_o     - head PC (0 when pop_valid_o=0)
//               pop_inst_o   - head instruction (0 when pop_valid_o=0)
//               count_o      - number of occupied entries
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_fetch_queue #(
  parameter int DEPTH      = common_def::IFQ_DEPTH_DEFAULT,
  parameter int ADDR_WIDTH = common_def::ADDR_WIDTH,
  parameter int INST_WIDTH = common_def::INST_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  input  logic                         push_valid_i,
  output logic                         push_ready_o,
  input  logic [ADDR_WIDTH-1:0]        push_pc_i,
  input  logic [INST_WIDTH-1:0]        push_inst_i,
  output logic                         pop_valid_o,
  input  logic                         pop_ready_i,
  output logic [ADDR_WIDTH-1:0]        pop_pc_o,
  output logic [INST_WIDTH-1:0]        pop_inst_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  import common_def::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [INST_WIDTH-1:0] inst;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;

  logic            empty;
  logic            bypass;
  logic            push_fire;
  logic            pop_fire;
  logic            mem_write;
  logic            mem_pop;

  assign empty = (count_q == '0);

`ifdef IFQ_BYPASS_EN
  assign bypass = empty & push_valid_i & ~flush_i;
`else
  assign bypass = 1'b0;
`endif

  // Full is judged on the current count only; a same-cycle pop does not
  // make room for a push.
  assign push_ready_o = (count_q != CW'(DEPTH));
  assign pop_valid_o  = ~empty | bypass;

  assign push_fire = push_valid_i & push_ready_o;
  assign pop_fire  = pop_valid_o & pop_ready_i;

  // A bypassed entry that is consumed immediately never touches storage.
  assign mem_write = push_fire & ~(bypass & pop_ready_i);
  assign mem_pop   = pop_fire & ~bypass;

  always_comb begin
    pop_pc_o   = '0;
    pop_inst_o = '0;
    if (bypass) begin
      pop_pc_o   = push_pc_i;
      pop_inst_o = push_inst_i;
    end else if (!empty) begin
      pop_pc_o   = mem_q[head].pc;
      pop_inst_o = mem_q[head].inst;
    end
  end

  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else begin
      count_d = count_q + CW'(mem_write) - CW'(mem_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Storage is deliberately not reset; outputs are gated by occupancy.
  always_ff @(posedge clk) begin
    if (rst && !flush_i && mem_write) begin
      mem_q[tail] <= '{pc: push_pc_i, inst: push_inst_i};
    end
  end

  ifq_ptr #(.W(PW)) u_head_ptr (
    .clk   (clk),
    .rst   (rst),
    .clr_i (flush_i),
    .inc_i (mem_pop),
    .ptr_o (head)
  );

  ifq_ptr #(.W(PW)) u_tail_ptr (
    .clk   (clk),
    .rst   (rst),
    .clr_i (flush_i),
    .inc_i (mem_write),
    .ptr_o (tail)
  );

  assign count_o = count_q;

endmodule : inst_fetch_queue

`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
// ============================================================================
// Module      : tb_inst_fetch_queue
// Description : Self-checking bench for inst_fetch_queue. A queue-based model
//               tracks the expected contents; a compare process checks every
//               output on each falling edge, and directed sequences pin the
//               model with literal expectations before a randomized phase.
// Macro       : IFQ_BYPASS_EN - selects the same-cycle bypass expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_fetch_queue;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);
`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          push_valid = 1'b0;
  logic          push_ready;
  logic [31:0]   push_pc = '0;
  logic [31:0]   push_inst = '0;
  logic          pop_valid;
  logic          pop_ready = 1'b0;
  logic [31:0]   pop_pc;
  logic [31:0]   pop_inst;
  logic [CW-1:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] mq [$];
  bit          armed = 1'b0;

  always #5 clk = ~clk;

  inst_fetch_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .INST_WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush),
    .push_valid_i (push_valid),
    .push_ready_o (push_ready),
    .push_pc_i    (push_pc),
    .push_inst_i  (push_inst),
    .pop_valid_o  (pop_valid),
    .pop_ready_i  (pop_ready),
    .pop_pc_o     (pop_pc),
    .pop_inst_o   (pop_inst),
    .count_o      (count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: plain queue updated with the handshake rules.
  always @(posedge clk) begin
    int  sz;
    bit  byp;
    bit  do_pop;
    bit  do_push;
    if (!rst) begin
      mq.delete();
      armed = 1'b1;
    end else if (armed) begin
      if (flush) begin
        mq.delete();
      end else begin
        sz      = mq.size();
        byp     = BYP && (sz == 0) && push_valid;
        do_pop  = ((sz != 0) || byp) && pop_ready;
        do_push = push_valid && (sz < DEPTH);
        if (!(byp && pop_ready)) begin
          if (do_pop)  void'(mq.pop_front());
          if (do_push) mq.push_back({push_pc, push_inst});
        end
      end
    end
  end

  // Compare process: all outputs against the model on every falling edge.
  always @(negedge clk) begin
    int          sz;
    bit          byp;
    logic [63:0] exp_e;
    if (armed) begin
      sz    = mq.size();
      byp   = BYP && (sz == 0) && push_valid && !flush;
      exp_e = byp ? {push_pc, push_inst} : ((sz != 0) ? mq[0] : 64'h0);
      chk("count",      64'(count),      64'(sz));
      chk("push_ready", 64'(push_ready), 64'(sz != DEPTH));
      chk("pop_valid",  64'(pop_valid),  64'((sz != 0) || byp));
      chk("pop_pc",     64'(pop_pc),     64'(exp_e[63:32]));
      chk("pop_inst",   64'(pop_inst),   64'(exp_e[31:0]));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    push_valid = 1'b0;
    pop_ready  = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic offer(input logic [31:0] pc);
    push_valid = 1'b1;
    push_pc    = pc;
    push_inst  = $urandom;
  endtask

  initial begin
    // Reset / idle
    rst = 1'b0;
    idle();
    step();
    step();
    rst = 1'b1;
    #1;
    chk("rst_pop_valid",  64'(pop_valid),  64'd0);
    chk("rst_pop_pc",     64'(pop_pc),     64'd0);
    chk("rst_push_ready", 64'(push_ready), 64'd1);
    chk("rst_count",      64'(count),      64'd0);

    // Fill to full
    for (int i = 0; i < 4; i++) begin
      offer(32'h100 + 32'(4 * i));
      step();
    end
    idle();
    #1;
    chk("full_count",      64'(count),      64'd4);
    chk("full_push_ready", 64'(push_ready), 64'd0);

    // Full with concurrent push and pop: only the pop fires
    offer(32'h1F0);
    pop_ready = 1'b1;
    #1;
    chk("fullpop_head", 64'(pop_pc), 64'h100);
    step();
    idle();
    #1;
    chk("fullpop_count", 64'(count),  64'd3);
    chk("fullpop_next",  64'(pop_pc), 64'h104);

    // Drain in order
    pop_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("drain_pc", 64'(pop_pc), 64'(32'h104 + 32'(4 * k)));
      step();
    end
    idle();
    #1;
    chk("drain_count", 64'(count), 64'd0);

    // Wrap-around at count=2
    offer(32'h400); step();
    offer(32'h404); step();
    for (int i = 0; i < 10; i++) begin
      offer(32'h408 + 32'(4 * i));
      pop_ready = 1'b1;
      #1;
      chk("wrap_pc", 64'(pop_pc), 64'(32'h400 + 32'(4 * i)));
      step();
      chk("wrap_count", 64'(count), 64'd2);
    end
    idle();
    pop_ready = 1'b1;
    step();
    step();
    idle();

    // Flush with a concurrent push
    for (int i = 0; i < 3; i++) begin
      offer(32'h500 + 32'(4 * i));
      step();
    end
    idle();
    #1;
    chk("preflush_count", 64'(count), 64'd3);
    flush = 1'b1;
    offer(32'h5F0);
    step();
    idle();
    #1;
    chk("flush_count",     64'(count),     64'd0);
    chk("flush_pop_valid", 64'(pop_valid), 64'd0);
    offer(32'h200);
    step();
    idle();
    #1;
    chk("postflush_valid", 64'(pop_valid), 64'd1);
    chk("postflush_pc",    64'(pop_pc),    64'h200);
    pop_ready = 1'b1;
    step();
    idle();

    // Bypass / minimum latency from an empty queue
    offer(32'h300);
    pop_ready = 1'b1;
    #1;
    if (BYP) begin
      chk("byp_valid", 64'(pop_valid), 64'd1);
      chk("byp_pc",    64'(pop_pc),    64'h300);
    end else begin
      chk("lat_valid0", 64'(pop_valid), 64'd0);
    end
    step();
    push_valid = 1'b0;
    #1;
    if (BYP) begin
      chk("byp_count", 64'(count), 64'd0);
    end else begin
      chk("lat_valid1", 64'(pop_valid), 64'd1);
      chk("lat_pc",     64'(pop_pc),    64'h300);
    end
    step();
    idle();
    step();

    // Randomized phase
    for (int c = 0; c < 3000; c++) begin
      rst        = ($urandom_range(0, 199) != 0);
      flush      = ($urandom_range(0, 29) == 0);
      push_valid = ($urandom_range(0, 99) < 60);
      pop_ready  = ($urandom_range(0, 99) < 50);
      push_pc    = $urandom;
      push_inst  = $urandom;
      step();
    end
    rst = 1'b1;
    idle();
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_inst_fetch_queue

`default_nettype wire
